tune_recorder: RTL and testbench
================================

Name: tune_recorder

Overview:
- Beat-synchronous note writer: records live keyboard note codes into an internal buffer, one entry per clk22 tick.
- Plays the buffer back as a looping tone stream.
- It is the writer/recorder counterpart of the beat-indexed music ROM reader. tone_out drives the same 50 MHz / tone divider path into note_gen as toneL/toneR.
- Sits between KeyboardDecoder-derived note codes and the audio chain.

Parameters:
ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W entries of 4-bit note codes
TONE_SIL, 50000000, tone value emitted for rest/silence (divider result = 1)

Ports:
clk22  input  1  beat clock (~23.8 Hz), one buffer entry per rising edge
rst  input  1  asynchronous, active-high reset
rec_en  input  1  record request; a rising edge (sampled on clk22) starts a recording
play_en  input  1  level playback request
clear  input  1  synchronous erase: length to 0, go IDLE
key_note  input  4  live note code: 0 = rest, 1..8 = C4..C5, 9..15 = rest
tone_out  output  32  tone frequency in Hz (registered)
beat_idx  output  ADDR_W  buffer index of the entry currently on tone_out (PLAY) or just written (RECORD)
length  output  ADDR_W+1  number of valid recorded entries (0..DEPTH)
rec_full  output  1  previous recording stopped because the buffer filled
state_out  output  2  00 IDLE, 01 RECORD, 10 PLAY

Behaviour:
- Reset (async): state IDLE, tone_out=TONE_SIL, beat_idx=0, length=0, rec_full=0, wr_ptr=rd_ptr=0, rec_en_q=0. Buffer contents are undefined and are not cleared.
- Note map (combinational, then registered into tone_out): 1→262, 2→294, 3→330, 4→349, 5→392, 6→440, 7→494, 8→523, else TONE_SIL.
- rec_start = rec_en & ~rec_en_q. rec_en_q is registered every clk22 edge.
- Priority on each edge: clear > rec_start > state-specific behaviour.
- clear (any state): state=IDLE, length=0, rec_full=0, beat_idx=0, tone_out=TONE_SIL, pointers=0. The buffer is untouched.
- rec_start (any state, clear=0): start recording on the same edge.
  - mem[0]=key_note, length=1, beat_idx=0, wr_ptr=1, rec_full=0, tone_out=map(key_note), state=RECORD.
  - This pre-empts PLAY.
  - If DEPTH==1, the edge goes straight to IDLE with rec_full=1.
- RECORD, rec_en=1: write mem[wr_ptr]=key_note, beat_idx=wr_ptr, length=wr_ptr+1, tone_out=map(key_note) (live echo), wr_ptr+=1.
  - If the written index is DEPTH-1: rec_full=1, state=IDLE, tone_out=TONE_SIL on the next edge. There is no wrap and no overwrite.
- RECORD, rec_en=0: state=IDLE, no write, length retained, tone_out=TONE_SIL.
- IDLE: tone_out=TONE_SIL.
  - If play_en=1, rec_en=0 and length!=0: state=PLAY.
  - On that same edge: tone_out=map(mem[0]), beat_idx=0, rd_ptr=(length==1)?0:1.
  - play_en with length==0 stays IDLE, silent.
- PLAY, play_en=1: tone_out=map(mem[rd_ptr]), beat_idx=rd_ptr, rd_ptr=(rd_ptr==length-1)?0:rd_ptr+1. Playback loops endlessly.
- PLAY, play_en=0: state=IDLE, tone_out=TONE_SIL on that edge.
- Latency: buffer entry k appears on tone_out on the edge that sets beat_idx=k. Playback period is exactly length beats.
- A level rec_en held high after a full stop does not restart recording; a new rising edge is required.
- Mid-operation async reset returns all outputs to reset values immediately, independent of clk22.
- Arithmetic widths: wr_ptr/rd_ptr are ADDR_W+1 bits internally; length compare is unsigned.

Test Plan:
1. Reset held with all inputs high, then released → tone_out=50000000, length=0, state_out=00 before any clk22 edge.
2. Record codes 1,3,0,8 on four edges with rec_en high, then drop rec_en.
   - During recording: tone_out 262,330,50000000,523; beat_idx 0..3.
   - After the drop: length=4, state IDLE, tone_out=50000000.
3. play_en high after scenario 2 → tone_out sequence 262,330,50000000,523,262,... with beat_idx 0,1,2,3,0. Drop play_en → next edge tone_out=50000000, state 00.
4. ADDR_W=2, hold rec_en for 6 edges with key_note=5.
   - length reaches 4, rec_full=1, state IDLE after edge 4; edges 5–6 cause no change.
   - Toggle rec_en low then high → recording restarts, rec_full=0, length=1.
5. During PLAY, pulse rec_en rising with key_note=2 → same edge: state RECORD, length=1, tone_out=294, beat_idx=0.
6. clear asserted together with rec_start → clear wins: length=0, state IDLE; a following play_en stays silent at tone_out=50000000.

Source files
------------

// File: rtl/tune_recorder.sv
// rtl/tune_recorder.sv - beat-synchronous note recorder with looping tone playback
//
// Records 4-bit key_note codes into an internal buffer, one entry per clk22
// rising edge, and plays the recorded buffer back as a looping tone stream.
//
// Ports:
//   clk22      beat clock, one buffer entry per rising edge
//   rst        asynchronous active-high reset
//   rec_en     record request; a rising edge starts a new recording
//   play_en    level playback request
//   clear      synchronous erase (length to 0, back to IDLE)
//   key_note   live note code (1..8 = C4..C5, anything else = rest)
//   tone_out   registered tone frequency in Hz
//   beat_idx   buffer index currently on tone_out (PLAY) or just written (RECORD)
//   length     number of valid recorded entries
//   rec_full   last recording stopped because the buffer filled
//   state_out  00 IDLE, 01 RECORD, 10 PLAY
module tune_recorder #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] TONE_SIL = 32'd50000000
) (
  input  logic              clk22,
  input  logic              rst,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              clear,
  input  logic [3:0]        key_note,
  output logic [31:0]       tone_out,
  output logic [ADDR_W-1:0] beat_idx,
  output logic [ADDR_W:0]   length,
  output logic              rec_full,
  output logic [1:0]        state_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10
  } state_t;

  state_t            state;
  logic [3:0]        mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              rec_en_q;
  logic              rec_start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [3:0]        rd_note;
  logic [3:0]        first_note;

  function automatic logic [31:0] note_to_tone(input logic [3:0] code);
    case (code)
      4'd1:    note_to_tone = 32'd262;
      4'd2:    note_to_tone = 32'd294;
      4'd3:    note_to_tone = 32'd330;
      4'd4:    note_to_tone = 32'd349;
      4'd5:    note_to_tone = 32'd392;
      4'd6:    note_to_tone = 32'd440;
      4'd7:    note_to_tone = 32'd494;
      4'd8:    note_to_tone = 32'd523;
      default: note_to_tone = TONE_SIL;
    endcase
  endfunction

  assign rec_start  = rec_en & ~rec_en_q;
  assign state_out  = state;
  assign rd_note    = mem[rd_ptr[ADDR_W-1:0]];
  assign first_note = mem[0];

  // Buffer write port: decoded with the same priority as the control FSM so a
  // clear on the same edge suppresses the write.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    if (!clear) begin
      if (rec_start) begin
        mem_we = 1'b1;
      end else if (state == S_RECORD && rec_en) begin
        mem_we = 1'b1;
        mem_wa = wr_ptr[ADDR_W-1:0];
      end
    end
  end

  // Buffer storage has no reset; its contents are undefined after rst.
  always_ff @(posedge clk22) begin
    if (mem_we && !rst) begin
      mem[mem_wa] <= key_note;
    end
  end

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tone_out <= TONE_SIL;
      beat_idx <= '0;
      length   <= '0;
      rec_full <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rec_en_q <= 1'b0;
    end else begin
      rec_en_q <= rec_en;
      if (clear) begin
        state    <= S_IDLE;
        tone_out <= TONE_SIL;
        beat_idx <= '0;
        length   <= '0;
        rec_full <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else if (rec_start) begin
        // Entry 0 is written and echoed on the edge that starts recording.
        tone_out <= note_to_tone(key_note);
        beat_idx <= '0;
        length   <= {{ADDR_W{1'b0}}, 1'b1};
        wr_ptr   <= {{ADDR_W{1'b0}}, 1'b1};
        if (LAST_IDX == '0) begin
          rec_full <= 1'b1;
          state    <= S_IDLE;
        end else begin
          rec_full <= 1'b0;
          state    <= S_RECORD;
        end
      end else begin
        case (state)
          S_RECORD: begin
            if (rec_en) begin
              tone_out <= note_to_tone(key_note);
              beat_idx <= wr_ptr[ADDR_W-1:0];
              length   <= wr_ptr + 1'b1;
              wr_ptr   <= wr_ptr + 1'b1;
              // Buffer filled: stop without wrapping; silence follows next edge.
              if (wr_ptr == LAST_IDX) begin
                rec_full <= 1'b1;
                state    <= S_IDLE;
              end
            end else begin
              tone_out <= TONE_SIL;
              state    <= S_IDLE;
            end
          end
          S_PLAY: begin
            if (play_en) begin
              tone_out <= note_to_tone(rd_note);
              beat_idx <= rd_ptr[ADDR_W-1:0];
              rd_ptr   <= (rd_ptr == length - 1'b1) ? '0 : rd_ptr + 1'b1;
            end else begin
              tone_out <= TONE_SIL;
              state    <= S_IDLE;
            end
          end
          default: begin
            tone_out <= TONE_SIL;
            if (play_en && !rec_en && length != '0) begin
              // Entry 0 goes out on the entering edge so the loop period is
              // exactly length beats.
              state    <= S_PLAY;
              tone_out <= note_to_tone(first_note);
              beat_idx <= '0;
              rd_ptr   <= (length == {{ADDR_W{1'b0}}, 1'b1}) ? '0 : {{ADDR_W{1'b0}}, 1'b1};
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_recorder.sv
// tb/tb_tune_recorder.sv - directed self-checking bench for tune_recorder
module tb_tune_recorder;

  localparam logic [31:0] SIL = 32'd50000000;

  logic        clk22;
  logic        rst;

  logic        rec_en_a, play_en_a, clear_a;
  logic [3:0]  key_a;
  logic [31:0] tone_a;
  logic [7:0]  beat_a;
  logic [8:0]  len_a;
  logic        full_a;
  logic [1:0]  st_a;

  logic        rec_en_b, play_en_b, clear_b;
  logic [3:0]  key_b;
  logic [31:0] tone_b;
  logic [1:0]  beat_b;
  logic [2:0]  len_b;
  logic        full_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  tune_recorder #(.ADDR_W(8)) dut_a (
    .clk22(clk22), .rst(rst), .rec_en(rec_en_a), .play_en(play_en_a),
    .clear(clear_a), .key_note(key_a), .tone_out(tone_a), .beat_idx(beat_a),
    .length(len_a), .rec_full(full_a), .state_out(st_a)
  );

  tune_recorder #(.ADDR_W(2)) dut_b (
    .clk22(clk22), .rst(rst), .rec_en(rec_en_b), .play_en(play_en_b),
    .clear(clear_b), .key_note(key_b), .tone_out(tone_b), .beat_idx(beat_b),
    .length(len_b), .rec_full(full_b), .state_out(st_b)
  );

  initial begin
    clk22 = 1'b0;
    forever #10 clk22 = ~clk22;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk22);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] t, input logic [31:0] b,
                       input logic [31:0] l, input logic [31:0] s);
    chk({tag, "_tone"}, tone_a, t);
    chk({tag, "_beat"}, {24'd0, beat_a}, b);
    chk({tag, "_len"}, {23'd0, len_a}, l);
    chk({tag, "_state"}, {30'd0, st_a}, s);
  endtask

  task automatic chk_b(input string tag, input logic [31:0] t, input logic [31:0] l,
                       input logic [31:0] f, input logic [31:0] s);
    chk({tag, "_tone"}, tone_b, t);
    chk({tag, "_len"}, {29'd0, len_b}, l);
    chk({tag, "_full"}, {31'd0, full_b}, f);
    chk({tag, "_state"}, {30'd0, st_b}, s);
  endtask

  initial begin
    // Reset with every input high
    rst = 1'b1;
    rec_en_a = 1'b1; play_en_a = 1'b1; clear_a = 1'b1; key_a = 4'hF;
    rec_en_b = 1'b1; play_en_b = 1'b1; clear_b = 1'b1; key_b = 4'hF;
    #25;
    chk_a("rst_held", SIL, 0, 0, 0);
    rec_en_a = 1'b0; play_en_a = 1'b0; clear_a = 1'b0; key_a = 4'd0;
    rec_en_b = 1'b0; play_en_b = 1'b0; clear_b = 1'b0; key_b = 4'd0;
    rst = 1'b0;
    #1;
    chk_a("rst_rel", SIL, 0, 0, 0);
    chk({"rst_full"}, {31'd0, full_a}, 0);
    chk_b("rst_b", SIL, 0, 0, 0);

    // Record 1,3,0,8 then drop rec_en
    rec_en_a = 1'b1; key_a = 4'd1; step(); chk_a("rec0", 262, 0, 1, 1);
    key_a = 4'd3; step(); chk_a("rec1", 330, 1, 2, 1);
    key_a = 4'd0; step(); chk_a("rec2", SIL, 2, 3, 1);
    key_a = 4'd8; step(); chk_a("rec3", 523, 3, 4, 1);
    rec_en_a = 1'b0; key_a = 4'd5; step();
    chk({"rec_stop_len"}, {23'd0, len_a}, 4);
    chk({"rec_stop_state"}, {30'd0, st_a}, 0);
    chk({"rec_stop_tone"}, tone_a, SIL);

    // Looping playback
    play_en_a = 1'b1;
    step(); chk_a("play0", 262, 0, 4, 2);
    step(); chk_a("play1", 330, 1, 4, 2);
    step(); chk_a("play2", SIL, 2, 4, 2);
    step(); chk_a("play3", 523, 3, 4, 2);
    step(); chk_a("play4", 262, 0, 4, 2);
    play_en_a = 1'b0; step();
    chk({"play_stop_tone"}, tone_a, SIL);
    chk({"play_stop_state"}, {30'd0, st_a}, 0);

    // Record rising edge pre-empts playback
    play_en_a = 1'b1;
    step(); chk_a("pre_play0", 262, 0, 4, 2);
    step(); chk_a("pre_play1", 330, 1, 4, 2);
    rec_en_a = 1'b1; key_a = 4'd2; step(); chk_a("preempt", 294, 0, 1, 1);
    rec_en_a = 1'b0; play_en_a = 1'b0; step(); chk_a("preempt_stop", SIL, 0, 1, 0);

    // clear beats a simultaneous rec_start
    rec_en_a = 1'b1; clear_a = 1'b1; key_a = 4'd4; step();
    chk_a("clear", SIL, 0, 0, 0);
    chk({"clear_full"}, {31'd0, full_a}, 0);
    rec_en_a = 1'b0; clear_a = 1'b0; play_en_a = 1'b1;
    step(); chk_a("clear_play0", SIL, 0, 0, 0);
    step(); chk_a("clear_play1", SIL, 0, 0, 0);
    play_en_a = 1'b0;

    // ADDR_W=2: fill the 4-entry buffer with rec_en held for 6 edges
    rec_en_b = 1'b1; key_b = 4'd5;
    step(); chk_b("fill1", 392, 1, 0, 1);
    step(); chk_b("fill2", 392, 2, 0, 1);
    step(); chk_b("fill3", 392, 3, 0, 1);
    step(); chk_b("fill4", 392, 4, 1, 0);
    chk({"fill4_beat"}, {30'd0, beat_b}, 3);
    step(); chk_b("fill5", SIL, 4, 1, 0);
    step(); chk_b("fill6", SIL, 4, 1, 0);
    rec_en_b = 1'b0; step(); chk_b("fill_low", SIL, 4, 1, 0);
    rec_en_b = 1'b1; step(); chk_b("restart", 392, 1, 0, 1);

    // Asynchronous reset mid-recording, applied away from any edge
    #5 rst = 1'b1;
    #1;
    chk_b("arst_b", SIL, 0, 0, 0);
    chk_a("arst_a", SIL, 0, 0, 0);
    rec_en_b = 1'b0;
    #2 rst = 1'b0;

    // Single-entry playback loops on entry 0
    rec_en_b = 1'b1; key_b = 4'd7; step(); chk_b("one_rec", 494, 1, 0, 1);
    rec_en_b = 1'b0; step(); chk_b("one_idle", SIL, 1, 0, 0);
    play_en_b = 1'b1;
    step(); chk_b("one_play0", 494, 1, 0, 2);
    chk({"one_beat0"}, {30'd0, beat_b}, 0);
    step(); chk_b("one_play1", 494, 1, 0, 2);
    chk({"one_beat1"}, {30'd0, beat_b}, 0);
    play_en_b = 1'b0; step(); chk_b("one_stop", SIL, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
